// File: rtl/cpu_scoreboard_if.sv
// Issue, read, writeback and hazard/forward signals between decode,
// execute writeback and the register scoreboard.
interface cpu_scoreboard_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32
);
  logic              issue_valid_i;
  logic              issue_wen_i;
  logic [IDX_W-1:0]  issue_widx_i;
  logic              rd_en_i;
  logic [IDX_W-1:0]  rd_idx_a_i;
  logic [IDX_W-1:0]  rd_idx_b_i;
  logic              wb_valid_i;
  logic [IDX_W-1:0]  wb_idx_i;
  logic [DATA_W-1:0] wb_value_i;
  logic              stall_o;
  logic              fwd_a_o;
  logic              fwd_b_o;
  logic [DATA_W-1:0] fwd_value_o;

  modport master (
    output issue_valid_i, issue_wen_i, issue_widx_i,
    output rd_en_i, rd_idx_a_i, rd_idx_b_i,
    output wb_valid_i, wb_idx_i, wb_value_i,
    input  stall_o, fwd_a_o, fwd_b_o, fwd_value_o
  );

  modport slave (
    input  issue_valid_i, issue_wen_i, issue_widx_i,
    input  rd_en_i, rd_idx_a_i, rd_idx_b_i,
    input  wb_valid_i, wb_idx_i, wb_value_i,
    output stall_o, fwd_a_o, fwd_b_o, fwd_value_o
  );
endinterface

// File: rtl/cpu_scoreboard.sv
// Register scoreboard: per-register pending-write counters, RAW/WAW stall
// generation and writeback forwarding when the last pending write retires.
module cpu_scoreboard #(
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2,
  parameter int HCNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  cpu_scoreboard_if.slave   sb,
  output logic              busy_o,
  output logic              underflow_o,
  output logic [HCNT_W-1:0] hazard_cnt_o
);

  localparam logic [IDX_W:0]   NREGS_W  = (IDX_W+1)'(NREGS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [HCNT_W-1:0] HCNT_MAX = {HCNT_W{1'b1}};
  localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1'b1);

  // Indices beyond the tracked range never count and never look pending.
  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NREGS_W);
  endfunction

  logic [CNT_W-1:0] cnt_r [NREGS];
  logic             underflow_r;
  logic [HCNT_W-1:0] hazard_cnt_r;

  logic [CNT_W-1:0] cnt_a_s, cnt_b_s, cnt_w_s, cnt_wb_s;
  logic             last_a_s, last_b_s, raw_a_s, raw_b_s, waw_full_s;
  logic             stall_s, issue_acc_s, wb_ok_s, busy_s;
  logic [NREGS-1:0] inc_s, dec_s;

  // Counter lookups for every port; out-of-range indices read as zero.
  always_comb begin
    cnt_a_s  = CNT_ZERO;
    cnt_b_s  = CNT_ZERO;
    cnt_w_s  = CNT_ZERO;
    cnt_wb_s = CNT_ZERO;
    if (idx_ok(sb.rd_idx_a_i)) cnt_a_s = cnt_r[sb.rd_idx_a_i];
    else                       cnt_a_s = CNT_ZERO;
    if (idx_ok(sb.rd_idx_b_i)) cnt_b_s = cnt_r[sb.rd_idx_b_i];
    else                       cnt_b_s = CNT_ZERO;
    if (idx_ok(sb.issue_widx_i)) cnt_w_s = cnt_r[sb.issue_widx_i];
    else                         cnt_w_s = CNT_ZERO;
    if (idx_ok(sb.wb_idx_i)) cnt_wb_s = cnt_r[sb.wb_idx_i];
    else                     cnt_wb_s = CNT_ZERO;
  end

  // Hazard detection: a read is clean when the retiring write is its last one.
  always_comb begin
    last_a_s    = sb.wb_valid_i && (sb.wb_idx_i == sb.rd_idx_a_i) && (cnt_a_s == CNT_ONE);
    last_b_s    = sb.wb_valid_i && (sb.wb_idx_i == sb.rd_idx_b_i) && (cnt_b_s == CNT_ONE);
    raw_a_s     = sb.rd_en_i && sb.issue_valid_i && (cnt_a_s != CNT_ZERO) && !last_a_s;
    raw_b_s     = sb.rd_en_i && sb.issue_valid_i && (cnt_b_s != CNT_ZERO) && !last_b_s;
    waw_full_s  = sb.issue_valid_i && sb.issue_wen_i && (cnt_w_s == CNT_MAX);
    stall_s     = raw_a_s || raw_b_s || waw_full_s;
    issue_acc_s = sb.issue_valid_i && sb.issue_wen_i && !stall_s && idx_ok(sb.issue_widx_i);
    wb_ok_s     = sb.wb_valid_i && idx_ok(sb.wb_idx_i);
  end

  // Per-register increment/decrement strobes and the pending summary.
  always_comb begin
    inc_s  = {NREGS{1'b0}};
    dec_s  = {NREGS{1'b0}};
    busy_s = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      inc_s[i] = issue_acc_s && (sb.issue_widx_i == IDX_W'(i));
      dec_s[i] = wb_ok_s && (sb.wb_idx_i == IDX_W'(i));
      if (cnt_r[i] != CNT_ZERO) busy_s = 1'b1;
      else                      busy_s = busy_s;
    end
  end

  assign sb.stall_o     = stall_s;
  assign sb.fwd_a_o     = sb.rd_en_i && sb.issue_valid_i && last_a_s;
  assign sb.fwd_b_o     = sb.rd_en_i && sb.issue_valid_i && last_b_s;
  assign sb.fwd_value_o = sb.wb_value_i;
  assign busy_o         = busy_s;
  assign underflow_o    = underflow_r;
  assign hazard_cnt_o   = hazard_cnt_r;

  // State update: reset beats flush, flush beats issue/retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) cnt_r[i] <= CNT_ZERO;
      underflow_r  <= 1'b0;
      hazard_cnt_r <= {HCNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (flush_i)                                              cnt_r[i] <= CNT_ZERO;
        else if (inc_s[i] && !dec_s[i])                           cnt_r[i] <= cnt_r[i] + CNT_ONE;
        else if (dec_s[i] && !inc_s[i] && cnt_r[i] != CNT_ZERO)   cnt_r[i] <= cnt_r[i] - CNT_ONE;
        else                                                      cnt_r[i] <= cnt_r[i];
      end
      if (wb_ok_s && cnt_wb_s == CNT_ZERO) underflow_r <= 1'b1;
      else                                 underflow_r <= underflow_r;
      if (stall_s && hazard_cnt_r != HCNT_MAX) hazard_cnt_r <= hazard_cnt_r + HCNT_ONE;
      else                                     hazard_cnt_r <= hazard_cnt_r;
    end
  end

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Directed bench for cpu_scoreboard: stimulus queues expectations per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_cpu_scoreboard;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  localparam int S_STALL = 0, S_FWDA = 1, S_FWDB = 2, S_FVAL = 3,
                 S_BUSY = 4, S_UF = 5, S_HCNT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        busy, uf;
  logic [15:0] hcnt;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];

  cpu_scoreboard_if #(.IDX_W(4), .DATA_W(32)) sbif();

  cpu_scoreboard #(.NREGS(16), .IDX_W(4), .DATA_W(32), .CNT_W(2), .HCNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .sb           (sbif),
    .busy_o       (busy),
    .underflow_o  (uf),
    .hazard_cnt_o (hcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      S_STALL: return {31'd0, sbif.stall_o};
      S_FWDA:  return {31'd0, sbif.fwd_a_o};
      S_FWDB:  return {31'd0, sbif.fwd_b_o};
      S_FVAL:  return sbif.fwd_value_o;
      S_BUSY:  return {31'd0, busy};
      S_UF:    return {31'd0, uf};
      S_HCNT:  return {16'd0, hcnt};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: compare every expectation registered for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e   = q.pop_front();
      got = dut_val(e.sel);
      total++;
      if (e.cyc != cyc || got !== e.exp) begin
        bad++;
        $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", e.name, cyc, got, e.exp);
      end
    end
  end

  task automatic expect_v(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic drive(input logic iv, input logic wen, input int widx,
                       input logic rden, input int ra, input int rb,
                       input logic wbv, input int wbi, input logic [31:0] wbval,
                       input logic fl);
    @(posedge clk); #1;
    sbif.issue_valid_i = iv;
    sbif.issue_wen_i   = wen;
    sbif.issue_widx_i  = 4'(widx);
    sbif.rd_en_i       = rden;
    sbif.rd_idx_a_i    = 4'(ra);
    sbif.rd_idx_b_i    = 4'(rb);
    sbif.wb_valid_i    = wbv;
    sbif.wb_idx_i      = 4'(wbi);
    sbif.wb_value_i    = wbval;
    flush              = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
  endtask

  initial begin
    sbif.issue_valid_i = 1'b0; sbif.issue_wen_i = 1'b0; sbif.issue_widx_i = 4'd0;
    sbif.rd_en_i = 1'b0; sbif.rd_idx_a_i = 4'd0; sbif.rd_idx_b_i = 4'd0;
    sbif.wb_valid_i = 1'b0; sbif.wb_idx_i = 4'd0; sbif.wb_value_i = 32'd0;
    idle(); idle();
    rst = 1'b0;
    expect_v("rst_stall", S_STALL, 32'd0);
    expect_v("rst_busy",  S_BUSY,  32'd0);
    expect_v("rst_uf",    S_UF,    32'd0);
    expect_v("rst_hcnt",  S_HCNT,  32'd0);
    expect_v("rst_fwda",  S_FWDA,  32'd0);

    // RAW on r3 resolved by forwarding
    drive(1'b1, 1'b1, 3, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t1_issue_stall", S_STALL, 32'd0);
    drive(1'b1, 1'b0, 0, 1'b1, 3, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t1_raw_stall", S_STALL, 32'd1);
    expect_v("t1_busy", S_BUSY, 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1, 3, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t1_raw_hold", S_STALL, 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1, 3, 0, 1'b1, 3, 32'hDEADBEEF, 1'b0);
    expect_v("t1_wb_stall", S_STALL, 32'd0);
    expect_v("t1_fwd_a", S_FWDA, 32'd1);
    expect_v("t1_fwd_b", S_FWDB, 32'd0);
    expect_v("t1_fwd_val", S_FVAL, 32'hDEADBEEF);
    idle();
    expect_v("t1_busy_after", S_BUSY, 32'd0);
    expect_v("t1_hcnt", S_HCNT, 32'd2);

    // Two outstanding writes to r5, read on both ports
    drive(1'b1, 1'b1, 5, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 5, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t2_second_issue", S_STALL, 32'd0);
    drive(1'b1, 1'b0, 0, 1'b1, 5, 5, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t2_raw_stall", S_STALL, 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1, 5, 5, 1'b1, 5, 32'h11111111, 1'b0);
    expect_v("t2_wb1_stall", S_STALL, 32'd1);
    expect_v("t2_wb1_fwda", S_FWDA, 32'd0);
    drive(1'b1, 1'b0, 0, 1'b1, 5, 5, 1'b1, 5, 32'h22222222, 1'b0);
    expect_v("t2_wb2_stall", S_STALL, 32'd0);
    expect_v("t2_wb2_fwda", S_FWDA, 32'd1);
    expect_v("t2_wb2_fwdb", S_FWDB, 32'd1);
    expect_v("t2_wb2_val", S_FVAL, 32'h22222222);
    idle();
    expect_v("t2_busy_after", S_BUSY, 32'd0);
    expect_v("t2_hcnt", S_HCNT, 32'd4);

    // Counter saturation on r7 (WAW full)
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
      expect_v("t3_fill", S_STALL, 32'd0);
    end
    drive(1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t3_full_stall", S_STALL, 32'd1);
    drive(1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b1, 7, 32'h77, 1'b0);
    expect_v("t3_full_wb_stall", S_STALL, 32'd1);
    drive(1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t3_accept", S_STALL, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 7, 32'h70, 1'b0);
      expect_v("t3_drain_busy", S_BUSY, 32'd1);
    end
    idle();
    expect_v("t3_busy_after", S_BUSY, 32'd0);
    expect_v("t3_hcnt", S_HCNT, 32'd6);

    // Same-cycle issue and retire on r2 leaves the count unchanged
    drive(1'b1, 1'b1, 2, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 2, 1'b0, 0, 0, 1'b1, 2, 32'h2, 1'b0);
    expect_v("t4_iss_ret_stall", S_STALL, 32'd0);
    expect_v("t4_iss_ret_busy", S_BUSY, 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1, 2, 0, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t4_still_pending", S_STALL, 32'd1);
    expect_v("t4_busy", S_BUSY, 32'd1);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 2, 32'h3, 1'b0);
    expect_v("t4_last_wb_busy", S_BUSY, 32'd1);
    idle();
    expect_v("t4_busy_after", S_BUSY, 32'd0);
    expect_v("t4_hcnt", S_HCNT, 32'd7);

    // Underflow on r9, sticky across flush
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 9, 32'h9, 1'b0);
    expect_v("t5_uf_before", S_UF, 32'd0);
    idle();
    expect_v("t5_uf_set", S_UF, 32'd1);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b1);
    idle();
    expect_v("t5_uf_after_flush", S_UF, 32'd1);

    // Flush clears pending r1/r4
    drive(1'b1, 1'b1, 1, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 4, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b1, 1, 4, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t6_raw_stall", S_STALL, 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1, 1, 4, 1'b0, 0, 32'd0, 1'b1);
    expect_v("t6_flush_cycle_stall", S_STALL, 32'd1);
    drive(1'b1, 1'b0, 0, 1'b1, 1, 4, 1'b0, 0, 32'd0, 1'b0);
    expect_v("t6_post_flush_stall", S_STALL, 32'd0);
    expect_v("t6_post_flush_busy", S_BUSY, 32'd0);
    expect_v("t6_hcnt", S_HCNT, 32'd9);
    expect_v("t6_uf", S_UF, 32'd1);

    // Long stall saturates the hazard counter
    drive(1'b1, 1'b1, 6, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    for (int i = 0; i < 65600; i++) begin
      drive(1'b1, 1'b0, 0, 1'b1, 6, 0, 1'b0, 0, 32'd0, 1'b0);
      if (i == 0) expect_v("t7_stall", S_STALL, 32'd1);
    end
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 6, 32'h6, 1'b0);
    expect_v("t7_hcnt_sat", S_HCNT, 32'h0000FFFF);
    idle();
    expect_v("t7_hcnt_hold", S_HCNT, 32'h0000FFFF);
    expect_v("t7_busy", S_BUSY, 32'd0);

    // Reset discards a write issued in the same cycle and clears sticky state
    drive(1'b1, 1'b1, 8, 1'b0, 0, 0, 1'b0, 0, 32'd0, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    expect_v("t8_busy", S_BUSY, 32'd0);
    expect_v("t8_uf", S_UF, 32'd0);
    expect_v("t8_hcnt", S_HCNT, 32'd0);

    idle(); idle();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_scoreboard.md
Name: cpu_scoreboard

Overview:
- Parametrised successor to the single-comparator read-after-write hazard check between decode and the register file write port.
- Tracks in-flight writes per architectural register with small pending counters, so multiple outstanding writes and multi-cycle execute units are handled correctly.
- Generates the decode/fetch/execute stall, and forwards the writeback value to either read port when that write is the last one pending.
- Sits beside the register file; issue side driven by decode, retire side driven by the execute writeback.

Parameters:
- NREGS, 16, number of architectural registers tracked.
- IDX_W, 4, register index width; NREGS must not exceed 2**IDX_W.
- DATA_W, 32, datapath width of forwarded value.
- CNT_W, 2, per-register pending-write counter width; max outstanding writes per register = 2**CNT_W-1.
- HCNT_W, 16, width of stall-cycle statistics counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous clear of all pending counters (pipeline flush).
- issue_valid_i  in  1  decode presents an instruction this cycle.
- issue_wen_i  in  1  instruction writes a register.
- issue_widx_i  in  IDX_W  destination register index.
- rd_en_i  in  1  instruction reads registers (both ports qualified).
- rd_idx_a_i  in  IDX_W  read port A index.
- rd_idx_b_i  in  IDX_W  read port B index.
- wb_valid_i  in  1  writeback retiring a register write this cycle.
- wb_idx_i  in  IDX_W  writeback register index.
- wb_value_i  in  DATA_W  writeback data.
- stall_o  out  1  hold fetch/decode/execute; issue not accepted.
- fwd_a_o  out  1  port A must take fwd_value_o instead of register file.
- fwd_b_o  out  1  port B likewise.
- fwd_value_o  out  DATA_W  forwarded data (equals wb_value_i).
- busy_o  out  1  at least one write pending.
- underflow_o  out  1  sticky error: writeback to register with zero pending.
- hazard_cnt_o  out  HCNT_W  saturating count of cycles with stall_o high.

Behaviour:
- State: cnt[NREGS] of CNT_W bits, underflow flag, hazard counter. Reset: all cnt=0, underflow_o=0, hazard_cnt_o=0; therefore stall_o=0, fwd_*=0, busy_o=0 after reset.
- Outputs stall_o, fwd_*, fwd_value_o, busy_o are combinational from current state and inputs (zero latency); counter updates take effect next cycle.
- last_p = wb_valid_i & wb_idx_i==rd_idx_p_i & cnt[rd_idx_p_i]==1.
- fwd_p_o = rd_en_i & issue_valid_i & last_p.
- raw_p = rd_en_i & issue_valid_i & cnt[rd_idx_p_i]!=0 & !last_p.
- waw_full = issue_valid_i & issue_wen_i & cnt[issue_widx_i]==2**CNT_W-1.
- stall_o = raw_a | raw_b | waw_full. An instruction reading and writing the same register is not self-hazarded.
- Accepted issue = issue_valid_i & issue_wen_i & !stall_o: cnt[issue_widx_i] +1.
- wb_valid_i: cnt[wb_idx_i] -1. Same register issued and retired in one cycle: net unchanged. Retire is never blocked by stall_o.
- Retire to cnt==0: counter stays 0, underflow_o set, held until rst_i.
- Indices >= NREGS: ignored for counting and compare as never pending.
- flush_i: all cnt cleared next cycle, overriding issue/retire that cycle; underflow_o and hazard_cnt_o unaffected.
- rst_i has priority over flush_i and all other inputs; reset mid-operation discards pending state immediately.
- hazard_cnt_o increments each cycle stall_o=1 (when not in reset), saturating at all-ones.

Test Plan:
- Reset, then issue write r3, next cycle read r3 on port A, no writeback -> stall_o=1 until writeback; during writeback cycle with wb_value_i=0xDEADBEEF: stall_o=0, fwd_a_o=1, fwd_value_o=0xDEADBEEF.
- Two issues writing r5 back-to-back, read r5; first writeback -> stall_o stays 1 (cnt 2 to 1); second writeback -> fwd_a_o=1, stall_o=0.
- Issue three writes to r7 (CNT_W=2), fourth write to r7 -> stall_o=1, cnt stays 3; writeback r7 same cycle -> still stalled that cycle, accepted next.
- Issue write r2 and writeback r2 in the same cycle with cnt[r2]=1 -> cnt[r2] remains 1, busy_o=1.
- Writeback r9 with nothing pending -> underflow_o=1 next cycle and stays 1 until rst_i; flush_i does not clear it.
- Pending writes on r1,r4 then flush_i -> busy_o=0 next cycle, reads of r1/r4 no stall; hold stall for 70000 cycles -> hazard_cnt_o=0xFFFF saturated.
